// File: rtl/sccb_cfg_sequencer_if.sv
// Write-request channel between the config sequencer and the shared SCCB/I2C byte-write engine.
interface sccb_cfg_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       wr_done;
  logic       wr_nack;

  modport master (
    output wr_req, wr_addr, wr_reg, wr_data,
    input  wr_ack, wr_done, wr_nack
  );

  modport slave (
    input  wr_req, wr_addr, wr_reg, wr_data,
    output wr_ack, wr_done, wr_nack
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Walks a {reg,val} camera init table and issues one byte-write per entry, with power-up
// delay, post-soft-reset delay, NACK retry and end-of-table detection.
module sccb_cfg_sequencer #(
  parameter logic [7:0]  SLAVE_ADDR   = 8'h42,
  parameter int          IDX_W        = 8,
  parameter logic [15:0] END_MARKER   = 16'hFFFF,
  parameter logic [7:0]  RST_REG      = 8'h12,
  parameter int          PWRUP_CYCLES = 25000,
  parameter int          SRST_CYCLES  = 25000,
  parameter int          MAX_RETRY    = 3
) (
  input  logic                 iCLK,
  input  logic                 rst,
  input  logic                 start_cfg,
  output logic [IDX_W-1:0]     lut_index,
  input  logic [15:0]          lut_data,
  sccb_cfg_sequencer_if.master wr,
  output logic                 busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [7:0]           err_count
);

  localparam int DLY_MAX = (PWRUP_CYCLES > SRST_CYCLES) ? PWRUP_CYCLES : SRST_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_SRST_DLY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [3:0]       retry_cnt;
  logic             wr_req_q;
  logic [7:0]       wr_reg_q;
  logic [7:0]       wr_data_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_soft_rst(input logic [7:0] r, input logic [7:0] d);
    return (r == RST_REG) && d[7];
  endfunction

  assign wr.wr_req  = wr_req_q;
  assign wr.wr_addr = SLAVE_ADDR;
  assign wr.wr_reg  = wr_reg_q;
  assign wr.wr_data = wr_data_q;

  assign busy = !(state inside {S_IDLE, S_DONE, S_ERROR});

  always_ff @(posedge iCLK) begin
    if (rst) begin
      state     <= S_PWRUP;
      lut_index <= '0;
      wr_req_q  <= 1'b0;
      wr_reg_q  <= 8'd0;
      wr_data_q <= 8'd0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_count <= 8'd0;
      retry_cnt <= 4'd0;
      dly_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          wr_req_q <= 1'b0;
          if (start_cfg) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_count <= 8'd0;
            lut_index <= '0;
            retry_cnt <= 4'd0;
            dly_cnt   <= '0;
            state     <= S_PWRUP;
          end
        end

        S_PWRUP: begin
          if (dly_cnt == DLY_W'(PWRUP_CYCLES - 1)) begin
            dly_cnt <= '0;
            state   <= S_FETCH;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        // Registered ROM: the entry for lut_index is visible one cycle later, in CHECK.
        S_FETCH: state <= S_CHECK;

        S_CHECK: begin
          if (lut_data == END_MARKER) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            wr_reg_q  <= lut_data[15:8];
            wr_data_q <= lut_data[7:0];
            wr_req_q  <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (wr.wr_ack) begin
            wr_req_q <= 1'b0;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wr.wr_done) begin
            if (!wr.wr_nack) begin
              retry_cnt <= 4'd0;
              if (is_soft_rst(wr_reg_q, wr_data_q)) begin
                dly_cnt <= '0;
                state   <= S_SRST_DLY;
              end else if (lut_index == IDX_LAST) begin
                cfg_done <= 1'b1;
                state    <= S_DONE;
              end else begin
                lut_index <= lut_index + 1'b1;
                state     <= S_FETCH;
              end
            end else begin
              err_count <= sat_inc8(err_count);
              if (retry_cnt < 4'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + 4'd1;
                wr_req_q  <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                cfg_err <= 1'b1;
                state   <= S_ERROR;
              end
            end
          end
        end

        S_SRST_DLY: begin
          if (dly_cnt == DLY_W'(SRST_CYCLES - 1)) begin
            dly_cnt <= '0;
            if (lut_index == IDX_LAST) begin
              cfg_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              lut_index <= lut_index + 1'b1;
              state     <= S_FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end

        default: begin
          wr_req_q <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
